// File: rtl/mips_pkg.sv
// Shared datapath constants and the reservation-station entry layout.
// Opcode encodings, tag/data/opcode widths and the packed entry record used
// by reservation_station and its testbench.
package mips_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OPC_W  = 6;

  localparam logic [OPC_W-1:0] ADD = 6'd0;
  localparam logic [OPC_W-1:0] SUB = 6'd1;
  localparam logic [OPC_W-1:0] AND = 6'd2;
  localparam logic [OPC_W-1:0] OR  = 6'd3;

  // One waiting instruction: operand values plus ready bits / producer tags.
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [TAG_W-1:0]  dest_tag;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              rj;
    logic              rk;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Dispatch picker for the reservation station.
// Grants the eligible entry with the largest age; ties (including the
// all-zero ages case) go to the lowest index.
//   eligible      : per-entry "may dispatch" vector
//   ages          : per-entry age, larger means older
//   grant_c       : one-hot grant (combinational)
//   grant_valid_c : some entry was granted (combinational)
module rs_select #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AGE_W = 2
) (
  input  logic [DEPTH-1:0]            eligible,
  input  logic [DEPTH-1:0][AGE_W-1:0] ages,
  output logic [DEPTH-1:0]            grant_c,
  output logic                        grant_valid_c
);

  logic [AGE_W-1:0] best_age;

  // Linear scan; strict '>' keeps the lower index on equal ages.
  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    best_age      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (eligible[i] && (!grant_valid_c || (ages[i] > best_age))) begin
        grant_c       = '0;
        grant_c[i]    = 1'b1;
        grant_valid_c = 1'b1;
        best_age      = ages[i];
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station feeding a single ALU.
// Holds up to DEPTH instructions, captures operands from the CDB, and
// dispatches one ready instruction at a time to the ALU, waiting for
// alu_done before the next dispatch (minimum start-to-start spacing 3).
// Optional build macro RS_OLDEST_FIRST_EN: dispatch the oldest eligible
// entry instead of the lowest-index one (adds per-entry age state).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   issue_valid/issue_ready  : issue handshake (ready = a free entry exists)
//   issue_opcode/dest_tag    : instruction opcode and result tag
//   issue_vj/vk, rj/rk, qj/qk: operand values, ready bits, producer tags
//   cdb_valid/tag/data       : result broadcast
//   alu_start/opcode/op1/op2/dest_tag : registered ALU dispatch
//   alu_done                 : ALU completion pulse
module reservation_station
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OPC_W-1:0]  issue_opcode,
  input  logic [TAG_W-1:0]  issue_dest_tag,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_rj,
  input  logic              issue_rk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              alu_start,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [TAG_W-1:0]  alu_dest_tag,
  input  logic              alu_done
);

  localparam int unsigned AGE_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  rs_entry_t ent_q [DEPTH];
  logic      busy_q;
  logic      start_d1_q;

  logic [DEPTH-1:0]            valid_c;
  logic [DEPTH-1:0]            eligible_c;
  logic [DEPTH-1:0]            issue_sel_c;
  logic [DEPTH-1:0]            next_valid_c;
  logic [DEPTH-1:0]            grant_c;
  logic                        grant_valid_c;
  logic [DEPTH-1:0][AGE_W-1:0] age_c;
  logic                        issue_fire_c;
  logic                        dispatch_c;
  logic                        slot_found_c;
  rs_entry_t                   new_ent_c;
  rs_entry_t                   disp_ent_c;

  // Per-entry status vectors from registered state.
  always_comb begin
    valid_c    = '0;
    eligible_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_c[i]    = ent_q[i].valid;
      eligible_c[i] = ent_q[i].valid && ent_q[i].rj && ent_q[i].rk;
    end
  end

  // Lowest-index free entry; never the one being dispatched, since that is valid.
  always_comb begin
    issue_sel_c  = '0;
    slot_found_c = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!valid_c[i] && !slot_found_c) begin
        issue_sel_c[i] = 1'b1;
        slot_found_c   = 1'b1;
      end
    end
  end

  assign issue_fire_c = issue_valid && issue_ready;

  // New entry, with a same-cycle CDB match captured at issue.
  always_comb begin
    new_ent_c          = '0;
    new_ent_c.valid    = 1'b1;
    new_ent_c.opcode   = issue_opcode;
    new_ent_c.dest_tag = issue_dest_tag;
    new_ent_c.vj       = issue_vj;
    new_ent_c.vk       = issue_vk;
    new_ent_c.rj       = issue_rj;
    new_ent_c.rk       = issue_rk;
    new_ent_c.qj       = issue_qj;
    new_ent_c.qk       = issue_qk;
    if (!issue_rj && cdb_valid && (issue_qj == cdb_tag)) begin
      new_ent_c.rj = 1'b1;
      new_ent_c.vj = cdb_data;
    end
    if (!issue_rk && cdb_valid && (issue_qk == cdb_tag)) begin
      new_ent_c.rk = 1'b1;
      new_ent_c.vk = cdb_data;
    end
  end

  rs_select #(
    .DEPTH(DEPTH),
    .AGE_W(AGE_W)
  ) u_select (
    .eligible      (eligible_c),
    .ages          (age_c),
    .grant_c       (grant_c),
    .grant_valid_c (grant_valid_c)
  );

  // ALU free (or freeing this cycle) and not within two cycles of the last start.
  assign dispatch_c = grant_valid_c && (!busy_q || alu_done) && !alu_start && !start_d1_q;

  // One-hot mux of the granted entry.
  always_comb begin
    disp_ent_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant_c[i]) disp_ent_c = ent_q[i];
    end
  end

  // Occupancy after this edge, used to register issue_ready.
  always_comb begin
    next_valid_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      next_valid_c[i] = (issue_fire_c && issue_sel_c[i]) ||
                        (valid_c[i] && !(dispatch_c && grant_c[i]));
    end
  end

  // Entry storage: issue write, dispatch clear, CDB wakeup.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (issue_fire_c && issue_sel_c[i]) begin
          ent_q[i] <= new_ent_c;
        end else begin
          if (dispatch_c && grant_c[i]) ent_q[i].valid <= 1'b0;
          if (cdb_valid && ent_q[i].valid && !ent_q[i].rj && (ent_q[i].qj == cdb_tag)) begin
            ent_q[i].rj <= 1'b1;
            ent_q[i].vj <= cdb_data;
          end
          if (cdb_valid && ent_q[i].valid && !ent_q[i].rk && (ent_q[i].qk == cdb_tag)) begin
            ent_q[i].rk <= 1'b1;
            ent_q[i].vk <= cdb_data;
          end
        end
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  // Age = number of currently valid entries issued after this one, so ages
  // of valid entries stay distinct and bounded by DEPTH-1.
  logic [DEPTH-1:0][AGE_W-1:0] age_q;
  logic [AGE_W-1:0]            disp_age_c;

  always_comb begin
    disp_age_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (grant_c[i]) disp_age_c = age_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (issue_fire_c && issue_sel_c[i]) begin
          age_q[i] <= '0;
        end else if (valid_c[i] && !(dispatch_c && grant_c[i])) begin
          // Older entries lose one younger neighbour when a younger one dispatches.
          age_q[i] <= age_q[i] + AGE_W'(issue_fire_c)
                    - AGE_W'(dispatch_c && (age_q[i] < disp_age_c) ? 1'b0 :
                             (dispatch_c && (age_q[i] > disp_age_c)));
        end
      end
    end
  end

  assign age_c = age_q;
`else
  assign age_c = '0;
`endif

  // ALU dispatch register, busy tracking and issue_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= 1'b0;
      start_d1_q   <= 1'b0;
      alu_start    <= 1'b0;
      alu_opcode   <= '0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      alu_dest_tag <= '0;
      issue_ready  <= 1'b1;
    end else begin
      alu_start   <= dispatch_c;
      start_d1_q  <= alu_start;
      issue_ready <= ~(&next_valid_c);
      if (dispatch_c) begin
        alu_opcode   <= disp_ent_c.opcode;
        alu_op1      <= disp_ent_c.vj;
        alu_op2      <= disp_ent_c.vk;
        alu_dest_tag <= disp_ent_c.dest_tag;
        busy_q       <= 1'b1;
      end else if (alu_done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
